// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter serialising CPU and DMA requests onto one memory port.
// Each transaction runs IDLE (grant) -> ACCESS (memory strobe) -> RESP (rvalid to the winner).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, id_q, id_d, rr_q, rr_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic grant, win, err, go;
  always_comb begin
    grant = rst_n && state_q == IDLE && (req0 || req1);
    // rr_q holds the last granted port, so on contention the other one wins
    win = (req0 && req1) ? ~rr_q : req1;
    err = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) ||
          (size_q == 2'b10 && addr_q[1:0] != 2'b00) || |addr_q[ADDR_W-1:10];
    go = state_q == ACCESS && !err;
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = grant ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
    rr_d = grant ? win : rr_q;
    id_d = grant ? win : id_q;
    we_d = grant ? (win ? we1 : we0) : we_q;
    size_d = grant ? (win ? size1 : size0) : size_q;
    addr_d = grant ? (win ? addr1 : addr0) : addr_q;
    wdata_d = grant ? (win ? wdata1 : wdata0) : wdata_q;
    rdata_d = state_q == ACCESS ? ((go && !we_q) ? mem_rdata : '0) : rdata_q;
    gnt0 = grant && !win;
    gnt1 = grant && win;
    rvalid0 = state_q == RESP && !id_q;
    rvalid1 = state_q == RESP && id_q;
    err0 = rvalid0 && err;
    err1 = rvalid1 && err;
    rdata0 = rvalid0 ? rdata_q : '0;
    rdata1 = rvalid1 ? rdata_q : '0;
    // a faulty request never reaches the memory, not even its address
    mem_read = go && !we_q;
    mem_write = go && we_q;
    mem_size = go ? size_q : '0;
    mem_addr = go ? addr_q : '0;
    mem_wdata = go ? wdata_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 1'b1;
      id_q <= 1'b0;
      we_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      we_q <= we_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized bench; a transaction-level model predicts grants,
// memory strobes and responses, and a monitor scores each rvalid against a queue of expectations.
module tb_mem_arbiter;
  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0, req1, we0, we1;
  logic [1:0] size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] mem_size;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] env_mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  bit ref_init, rr, saw0, saw1, e0, e1, ok;
  int phase;
  bit cur_we, cur_err;
  logic [1:0] cur_size;
  logic [31:0] cur_addr, cur_wdata;
  exp_t sb[$];
  exp_t x, y;
  int gport[$];
  int gcyc[$];
  logic [31:0] last_rd [2];
  logic last_err [2];
  logic [9:0] ea;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external 1 KiB byte memory returning zero-extended little-endian data
  always_comb begin
    ea = mem_addr[9:0];
    mem_rdata = {env_mem[ea + 10'd3], env_mem[ea + 10'd2], env_mem[ea + 10'd1], env_mem[ea]};
    if (mem_size == 2'd0) mem_rdata[31:8] = '0;
    else if (mem_size == 2'd1) mem_rdata[31:16] = '0;
  end
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= 8'h00;
    end else if (mem_write) begin
      env_mem[ea] <= mem_wdata[7:0];
      if (mem_size != 2'd0) env_mem[ea + 10'd1] <= mem_wdata[15:8];
      if (mem_size == 2'd2) begin
        env_mem[ea + 10'd2] <= mem_wdata[23:16];
        env_mem[ea + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] s, input logic [31:0] a);
    return s == 2'd3 || a >= 32'd1024 || (a % (32'd1 << s)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < (1 << s); i++) v |= 32'(ref_mem[a[9:0] + 10'(i)]) << (8 * i);
    return v;
  endfunction

  // model: predicts grants and memory strobes, pushes the expected response at grant time
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      phase = 0;
      rr = 1'b1;
      saw0 = 1'b0;
      saw1 = 1'b0;
      sb.delete();
    end else begin
      e0 = phase == 0 && req0 && (!req1 || rr);
      e1 = phase == 0 && req1 && !e0;
      chk("gnt0", gnt0, e0);
      chk("gnt1", gnt1, e1);
      ok = phase == 1 && !cur_err;
      chk("mem_read", mem_read, ok && !cur_we);
      chk("mem_write", mem_write, ok && cur_we);
      if (phase != 1 || !cur_err) begin
        chk("mem_addr", mem_addr, ok ? cur_addr : 32'd0);
        chk("mem_size", mem_size, ok ? cur_size : 2'd0);
        chk("mem_wdata", mem_wdata, ok ? cur_wdata : 32'd0);
      end
      saw0 = gnt0;
      saw1 = gnt1;
      if (gnt0 || gnt1) begin
        gport.push_back(int'(gnt1));
        gcyc.push_back(cyc);
      end
      if (e0 || e1) begin
        cur_we = e1 ? we1 : we0;
        cur_size = e1 ? size1 : size0;
        cur_addr = e1 ? addr1 : addr0;
        cur_wdata = e1 ? wdata1 : wdata0;
        cur_err = ref_err(cur_size, cur_addr);
        x.port = e1;
        x.err = cur_err;
        x.rdata = (cur_err || cur_we) ? 32'd0 : ref_load(cur_size, cur_addr);
        x.cyc = cyc;
        if (!cur_err && cur_we)
          for (int i = 0; i < (1 << cur_size); i++) ref_mem[cur_addr[9:0] + 10'(i)] = cur_wdata[8*i +: 8];
        sb.push_back(x);
        rr = e1;
        phase = 1;
      end else begin
        phase = phase == 1 ? 2 : 0;
      end
    end
  end

  // monitor: scores every response the DUT presents
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid0 || rvalid1) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", {rvalid1, rvalid0}, 2'b00);
        end else begin
          y = sb.pop_front();
          chk("rv_port", {rvalid1, rvalid0}, y.port ? 2'b10 : 2'b01);
          chk("rv_err", y.port ? err1 : err0, y.err);
          chk("rv_rdata", y.port ? rdata1 : rdata0, y.rdata);
          chk("rv_latency", cyc - y.cyc, 2);
          last_rd[y.port] = y.port ? rdata1 : rdata0;
          last_err[y.port] = y.port ? err1 : err0;
        end
      end
      if (!rvalid0) chk("idle_resp0", {err0, rdata0}, 0);
      if (!rvalid1) chk("idle_resp1", {err1, rdata1}, 0);
    end
  end

  task automatic issue(input bit p, input bit w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (p) begin req1 = 1; we1 = w; size1 = s; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = w; size0 = s; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = p ? gnt1 : gnt0;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL gnt_timeout: port %0d never granted", p);
    end
    @(posedge clk); #1;
    if (p) req1 = 0; else req0 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_req(output logic w, output logic [1:0] s, output logic [31:0] a, output logic [31:0] d);
    w = 1'($urandom_range(0, 1));
    s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a = 32'($urandom_range(0, 63));
    if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
    if ($urandom_range(0, 15) == 0) a = a | (32'h400 << $urandom_range(0, 21));
    d = $urandom;
  endtask

  initial begin
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; size0 = 2; size1 = 2;
    addr0 = 32'h0; addr1 = 32'h4; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}, 0);
    chk("reset_data", {rdata0 | rdata1 | mem_wdata, mem_size}, 0);
    chk("reset_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 40 && gport.size() < 4; i++) @(posedge clk);
    #1;
    req0 = 0; req1 = 0;
    chk("cont_grants", gport.size(), 4);
    for (int i = 0; i < gport.size() && i < 4; i++) begin
      chk("cont_order", gport[i], i % 2);
      if (i > 0) chk("cont_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    drain();
    issue(0, 1, 2'd2, 32'h010, 32'hDEADBEEF);
    issue(0, 0, 2'd2, 32'h010, 32'h0);
    drain();
    chk("st_ld_rdata0", last_rd[0], 32'hDEADBEEF);
    chk("st_ld_err0", last_err[0], 0);
    issue(1, 0, 2'd2, 32'h006, 32'h0);
    drain();
    chk("misalign_err1", last_err[1], 1);
    chk("misalign_rdata1", last_rd[1], 0);
    issue(0, 1, 2'd0, 32'h400, 32'h11);
    drain();
    chk("oob_err0", last_err[0], 1);
    issue(0, 0, 2'd3, 32'h000, 32'h0);
    drain();
    chk("size3_err0", last_err[0], 1);
    issue(1, 1, 2'd0, 32'h003, 32'h123456A5);
    issue(1, 0, 2'd0, 32'h003, 32'h0);
    drain();
    chk("byte_rdata1", last_rd[1], 32'h000000A5);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (req0 && saw0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin rand_req(we0, size0, addr0, wdata0); req0 = 1; end
      else if (req0 && $urandom_range(0, 15) == 0) req0 = 0;
      if (req1 && saw1) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin rand_req(we1, size1, addr1, wdata1); req1 = 1; end
      else if (req1 && $urandom_range(0, 15) == 0) req1 = 0;
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    drain();
    chk("sb_empty", sb.size(), 0);
    // abort a store in ACCESS; 0x200 is outside the random address window
    @(posedge clk); #1;
    req0 = 1; we0 = 1; size0 = 2; addr0 = 32'h200; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort_gnt0", gnt0, 1);
    @(posedge clk); #1;
    req0 = 0;
    chk("abort_in_access", mem_write, 1);
    rst_n = 0;
    #1;
    chk("abort_write_drop", mem_write, 0);
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h0; addr1 = 32'h4;
    repeat (2) begin
      @(negedge clk);
      chk("abort_quiet", {rvalid0, rvalid1, gnt0, gnt1, rdata0}, 0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("abort_next_winner", {gnt1, gnt0}, 2'b01);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    drain();
    chk("abort_no_commit", {env_mem[10'h200], env_mem[10'h201], env_mem[10'h202], env_mem[10'h203]}, 0);
    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, requester and memory address width.
REQ-002 Parameter: DATA_W, 32, data width; only the value 32 is supported.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; asynchronous and active-low.
REQ-005 req0, req1  in  1 each  request from port 0 (CPU load/store) and port 1 (DMA).
REQ-006 we0, we1  in  1 each  1 = store, 0 = load.
REQ-007 size0, size1  in  2 each  access size: 00 byte, 01 half-word, 10 word, 11 illegal.
REQ-008 addr0, addr1  in  ADDR_W each  byte address.
REQ-009 wdata0, wdata1  in  DATA_W each  store data.
REQ-010 gnt0, gnt1  out  1 each  one-cycle pulse; the port's request is accepted and latched.
REQ-011 rvalid0, rvalid1  out  1 each  one-cycle completion pulse.
REQ-012 rdata0, rdata1  out  DATA_W each  load data; valid only while the matching rvalid is high.
REQ-013 err0, err1  out  1 each  error flag; valid only while the matching rvalid is high.
REQ-014 mem_read, mem_write  out  1 each  memory strobes.
REQ-015 mem_size  out  2  size presented to the memory.
REQ-016 mem_addr  out  ADDR_W  address presented to the memory.
REQ-017 mem_wdata  out  DATA_W  store data presented to the memory.
REQ-018 mem_rdata  in  DATA_W  asynchronous memory read data.

Function
REQ-019 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on any grant, ACCESS->RESP always, and RESP->IDLE always.
REQ-020 In IDLE, grant rules:
- only one port requesting: that port wins;
- both requesting: the port not granted most recently wins (round-robin).
REQ-021 The grant cycle SHALL:
- assert the winner's gnt for exactly that cycle;
- latch we, size, addr, wdata and the port id into internal registers.
REQ-022 Handshake: a requester SHALL hold req and its fields stable until it sees gnt; deasserting req before gnt withdraws the request with no side effect.
REQ-023 req SHALL be ignored in ACCESS and RESP; gnt is never asserted outside IDLE.
REQ-024 Error check, evaluated on the latched request; an error is flagged when any of these holds:
- size = 11;
- half-word with addr[0] = 1;
- word with addr[1:0] != 00;
- addr[ADDR_W-1:10] != 0 (outside the 1024-byte array).
REQ-025 ACCESS without error SHALL:
- drive mem_read = ~we and mem_write = we for exactly one cycle;
- drive mem_size, mem_addr and mem_wdata from the latched registers;
- commit a store on the rising edge that ends ACCESS;
- capture mem_rdata into the response register on that same edge for a load.
REQ-026 ACCESS with error SHALL keep mem_read = mem_write = 0, so memory is never touched.
REQ-027 In RESP, the granted port's rvalid SHALL be high for exactly one cycle, and:
- err reflects the REQ-024 check;
- rdata = captured data for an error-free load, otherwise 0.
REQ-028 The other port's rvalid, err and rdata SHALL be 0 in every state; rdata ports are 0 whenever their rvalid is low.
REQ-029 Timing: latency is grant cycle to rvalid = 2 cycles; peak throughput is one transaction per 3 cycles.
REQ-030 Outside ACCESS, mem_read and mem_write SHALL be 0 and mem_size, mem_addr and mem_wdata SHALL be 0.
REQ-031 The round-robin pointer SHALL update only on a grant, to the granted port id.

Reset
REQ-032 While rst_n = 0, the block SHALL:
- hold state IDLE;
- drive all outputs to 0;
- clear the latched request registers;
- set the round-robin pointer to 1, so port 0 wins the first contention.
REQ-033 Reset asserted mid-transaction SHALL abort it: no rvalid is produced, and mem_write drops immediately (asynchronously).
REQ-034 After rst_n deasserts, arbitration SHALL begin on the first rising edge.

Verification
REQ-035 Word store followed by load:
- stimulus: port 0 stores 0xDEADBEEF to 0x010, then loads 0x010;
- response: mem_write high one cycle, rvalid0 two cycles after gnt0, then load rdata0 = 0xDEADBEEF, err0 = 0.
REQ-036 Contention after reset:
- stimulus: req0 and req1 held high continuously;
- response: grant order 0,1,0,1; gnt pulses spaced 3 cycles apart; never both gnt high together.
REQ-037 Misaligned access:
- stimulus: port 1 word load from 0x006;
- response: mem_read stays 0, rvalid1 = 1 with err1 = 1 and rdata1 = 0.
REQ-038 Out-of-range and illegal size:
- stimulus: port 0 byte store to 0x400, then size = 11 to 0x000;
- response: both complete with err0 = 1 and no mem_write pulse.
REQ-039 Byte access:
- stimulus: port 1 byte store 0xA5 to 0x003, then byte load from 0x003;
- response: rdata1 = 0x000000A5.
REQ-040 Reset mid-operation:
- stimulus: rst_n driven low during ACCESS of a store;
- response: mem_write drops immediately, no rvalid, state IDLE, and port 0 wins the next contention.
